alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/alu_mc.sv | 179 +++++++++++++++++
 tb/tb_alu_mc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, flag bit indices and handshake FSM states.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_INC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_CMP  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_RR   = 5'd10;
  localparam logic [4:0] OP_RL   = 5'd11;
  localparam logic [4:0] OP_SETB = 5'd12;
  localparam logic [4:0] OP_CLRB = 5'd13;
  localparam logic [4:0] OP_SETF = 5'd14;
  localparam logic [4:0] OP_SWAP = 5'd15;

  localparam int FL_C   = 0;
  localparam int FL_V   = 1;
  localparam int FL_CMP = 2;
  localparam int FL_EQ  = 3;
  localparam int FL_F   = 4;
  localparam int FL_P   = 5;
  localparam int FL_N   = 6;
  localparam int FL_Z   = 7;
  localparam int FL_ILL = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// done marks the final step; res_lo/res_hi then carry the finished product or quotient/remainder.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   shl_w;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  // hi:lo is the product accumulator for MUL, remainder:quotient for DIV.
  always_comb begin
    sum_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    shl_w = {hi_q, lo_q[MSB]};
    ge    = shl_w >= {1'b0, d_q};
    if (div_q) begin
      hi_n = ge ? (shl_w[MSB:0] - d_q) : shl_w[MSB:0];
      lo_n = {lo_q[MSB-1:0], ge};
    end else begin
      hi_n = sum_w[WIDTH:1];
      lo_n = {sum_w[0], lo_q[MSB:1]};
    end
  end

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = mode_div;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = mode_div ? op_a : op_b;
      d_d    = mode_div ? op_b : op_a;
    end else if (busy_q) begin
      hi_d  = hi_n;
      lo_d  = lo_n;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign res_lo = lo_n;
  assign res_hi = hi_n;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle ops, WIDTH-cycle MUL/DIV; accept only in IDLE.
// Results/flags registered and held while out_valid && !out_ready.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int BPW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [BPW-1:0]   bit_position,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_0,
  output logic [WIDTH-1:0] result_1,
  output logic [15:0]      flag_reg
);

  localparam int MSB  = WIDTH - 1;
  localparam int HALF = WIDTH / 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_0_q, result_0_d;
  logic [WIDTH-1:0] result_1_q, result_1_d;
  logic [15:0]      flag_q, flag_d;

  logic [WIDTH-1:0] sc_r0, sc_r1, b_add, diff, bit_mask;
  logic [WIDTH:0]   sum_w;
  logic             sc_c, sc_v, sc_gt, sc_eq, sc_ill, sc_setf, iter_op;
  logic [15:0]      setf_mask;

  logic             md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  // Z/N/P always follow result_0; F is carried through untouched.
  function automatic logic [15:0] pack_flags(input logic [WIDTH-1:0] r, input logic c, input logic v,
                                             input logic gt, input logic eq, input logic ill,
                                             input logic f);
    logic [15:0] fl;
    fl         = '0;
    fl[FL_C]   = c;
    fl[FL_V]   = v;
    fl[FL_CMP] = gt;
    fl[FL_EQ]  = eq;
    fl[FL_F]   = f;
    fl[FL_P]   = ~^r;
    fl[FL_N]   = r[WIDTH-1];
    fl[FL_Z]   = ~|r;
    fl[FL_ILL] = ill;
    return fl;
  endfunction

  always_comb begin
    sc_r0     = '0;
    sc_r1     = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_gt     = 1'b0;
    sc_eq     = 1'b0;
    sc_ill    = 1'b0;
    sc_setf   = 1'b0;
    b_add     = (opcode == OP_INC) ? WIDTH'(1) : operand_2;
    sum_w     = {1'b0, operand_1} + {1'b0, b_add};
    diff      = operand_1 - operand_2;
    bit_mask  = WIDTH'(1) << bit_position;
    setf_mask = (int'(bit_position) <= FL_ILL) ? (16'h1 << bit_position) : 16'h0;
    iter_op   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_2 != '0));
    case (opcode)
      OP_ADD, OP_INC: begin
        sc_r0 = sum_w[MSB:0];
        sc_c  = sum_w[WIDTH];
        sc_v  = (operand_1[MSB] == b_add[MSB]) && (sum_w[MSB] != operand_1[MSB]);
      end
      OP_SUB: begin
        sc_r0 = diff;
        sc_c  = operand_1 < operand_2;
        sc_v  = (operand_1[MSB] != operand_2[MSB]) && (diff[MSB] != operand_1[MSB]);
      end
      OP_CMP: begin
        sc_r0 = diff;
        sc_c  = operand_1 < operand_2;
        sc_gt = operand_1 > operand_2;
        sc_eq = operand_1 == operand_2;
      end
      OP_MUL: ;
      // Only the divide-by-zero case completes here; real divides go iterative.
      OP_DIV: begin
        sc_r0 = '1;
        sc_r1 = operand_1;
        sc_v  = 1'b1;
      end
      OP_NOT:  sc_r0 = ~operand_1;
      OP_AND:  sc_r0 = operand_1 & operand_2;
      OP_OR:   sc_r0 = operand_1 | operand_2;
      OP_XOR:  sc_r0 = operand_1 ^ operand_2;
      OP_RR:   sc_r0 = {operand_1[0], operand_1[MSB:1]};
      OP_RL:   sc_r0 = {operand_1[MSB-1:0], operand_1[MSB]};
      OP_SWAP: sc_r0 = {operand_1[HALF-1:0], operand_1[MSB:HALF]};
      OP_SETB: sc_r0 = operand_1 | bit_mask;
      OP_CLRB: sc_r0 = operand_1 & ~bit_mask;
      OP_SETF: sc_setf = 1'b1;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_0_d = result_0_q;
    result_1_d = result_1_q;
    flag_d     = flag_q;
    md_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (iter_op) begin
            md_start = 1'b1;
            state_d  = S_ITER;
          end else begin
            result_0_d = sc_r0;
            result_1_d = sc_r1;
            flag_d     = sc_setf ? (flag_q | setf_mask)
                                 : pack_flags(sc_r0, sc_c, sc_v, sc_gt, sc_eq, sc_ill, flag_q[FL_F]);
            state_d    = S_DONE;
          end
        end
      end
      S_ITER: begin
        if (md_done) begin
          result_0_d = md_lo;
          result_1_d = md_hi;
          flag_d     = pack_flags(md_lo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, flag_q[FL_F]);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      result_0_q <= '0;
      result_1_q <= '0;
      flag_q     <= '0;
    end else begin
      state_q    <= state_d;
      result_0_q <= result_0_d;
      result_1_q <= result_1_d;
      flag_q     <= flag_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .mode_div (opcode == OP_DIV),
    .op_a     (operand_1),
    .op_b     (operand_2),
    .done     (md_done),
    .res_lo   (md_lo),
    .res_hi   (md_hi)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result_0  = result_0_q;
  assign result_1  = result_1_q;
  assign flag_reg  = flag_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc (WIDTH=16) against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [15:0] operand_1;
  logic [15:0] operand_2;
  logic [3:0]  bit_position;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_0;
  logic [15:0] result_1;
  logic [15:0] flag_reg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_flags;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .bit_position (bit_position),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_0     (result_0),
    .result_1     (result_1),
    .flag_reg     (flag_reg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic; updates m_flags as the ALU should.
  task automatic model_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] pos, output logic [15:0] r0, output logic [15:0] r1,
                          output int lat);
    int     ua, ub, sa, sb, s, ss;
    longint p;
    logic   c, v, gt, eq, ill, z, n, par;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r0 = 16'h0; r1 = 16'h0; lat = 1;
    c = 1'b0; v = 1'b0; gt = 1'b0; eq = 1'b0; ill = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        if (op == OP_INC) begin ub = 1; sb = 1; end
        s  = ua + ub;
        ss = sa + sb;
        r0 = 16'(s);
        c  = s > 65535;
        v  = (ss > 32767) || (ss < -32768);
      end
      OP_SUB: begin
        ss = sa - sb;
        r0 = 16'(ua - ub);
        c  = ua < ub;
        v  = (ss > 32767) || (ss < -32768);
      end
      OP_CMP: begin
        r0 = 16'(ua - ub);
        c  = ua < ub;
        gt = ua > ub;
        eq = ua == ub;
      end
      OP_MUL: begin
        p   = longint'(ua) * longint'(ub);
        r0  = 16'(p);
        r1  = 16'(p / 65536);
        lat = 17;
      end
      OP_DIV: begin
        if (ub == 0) begin
          r0 = 16'hFFFF;
          r1 = a;
          v  = 1'b1;
        end else begin
          r0  = 16'(ua / ub);
          r1  = 16'(ua % ub);
          lat = 17;
        end
      end
      OP_NOT:  r0 = ~a;
      OP_AND:  r0 = a & b;
      OP_OR:   r0 = a | b;
      OP_XOR:  r0 = a ^ b;
      OP_RR:   r0 = 16'((ua / 2) + (ua % 2) * 32768);
      OP_RL:   r0 = 16'((ua * 2) % 65536 + ua / 32768);
      OP_SWAP: r0 = 16'((ua % 256) * 256 + ua / 256);
      OP_SETB: r0 = a | 16'(1 << pos);
      OP_CLRB: r0 = a & ~16'(1 << pos);
      OP_SETF: ;
      default: ill = 1'b1;
    endcase
    if (op == OP_SETF) begin
      if (pos < 9) m_flags = m_flags | 16'(1 << pos);
    end else begin
      z   = (r0 == 16'h0);
      n   = (ua >= 0) && (r0 >= 16'h8000);
      par = ($countones(r0) % 2) == 0;
      m_flags = (m_flags & 16'h0010) | 16'(c) | (16'(v) << 1) | (16'(gt) << 2) | (16'(eq) << 3)
              | (16'(par) << 5) | (16'(n) << 6) | (16'(z) << 7) | (16'(ill) << 8);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] pos, input int hold);
    logic [15:0] e0, e1;
    int          elat, lat;
    model_op(op, a, b, pos, e0, e1, elat);
    check_val("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    opcode       = op;
    operand_1    = a;
    operand_2    = b;
    bit_position = pos;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    opcode       = 5'($urandom);
    operand_1    = 16'($urandom);
    operand_2    = 16'($urandom);
    bit_position = 4'($urandom);
    lat = 1;
    while (!out_valid && lat <= 40) begin
      check_val("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'(elat));
    check_val("result_0", 32'(result_0), 32'(e0));
    check_val("result_1", 32'(result_1), 32'(e1));
    check_val("flag_reg", 32'(flag_reg), 32'(m_flags));
    check_val("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_r0", 32'(result_0), 32'(e0));
      check_val("hold_r1", 32'(result_1), 32'(e1));
      check_val("hold_flags", 32'(flag_reg), 32'(m_flags));
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("released", 32'({out_valid, in_ready}), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rop;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 5'd0; operand_1 = 16'h0; operand_2 = 16'h0; bit_position = 4'd0;
    m_flags = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_r0", 32'(result_0), 32'd0);
    check_val("rst_r1", 32'(result_1), 32'd0);
    check_val("rst_flags", 32'(flag_reg), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 0);
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 0);
    run_op(OP_MUL, 16'h1234, 16'h5678, 4'd0, 0);
    run_op(OP_DIV, 16'd100, 16'd7, 4'd0, 1);
    run_op(OP_DIV, 16'd5, 16'd0, 4'd0, 0);
    run_op(OP_SETF, 16'h0, 16'h0, 4'd4, 0);
    run_op(OP_AND, 16'h00F0, 16'h0F00, 4'd0, 0);
    run_op(OP_SETF, 16'h0, 16'h0, 4'd9, 0);
    run_op(OP_CMP, 16'd3, 16'd5, 4'd0, 5);
    run_op(5'b10101, 16'h1234, 16'h4321, 4'd0, 0);
    run_op(OP_SUB, 16'h8000, 16'h0001, 4'd0, 0);
    run_op(OP_SWAP, 16'hAB12, 16'h0, 4'd0, 0);

    for (int k = 0; k < 300; k++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op(rop, ra, rb, 4'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an iterative divide.
    in_valid = 1'b1; opcode = OP_DIV; operand_1 = 16'd100; operand_2 = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_flags = 16'h0;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    check_val("midrst_r0", 32'(result_0), 32'd0);
    check_val("midrst_r1", 32'(result_1), 32'd0);
    check_val("midrst_flags", 32'(flag_reg), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_DIV, 16'd100, 16'd7, 4'd0, 0);
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 4'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
